// File: rtl/ternary_weight_loader_if.sv
// Host-side bus for the ternary weight loader: byte stream in, committed
// weight matrix and status out.
interface ternary_weight_loader_if #(
    parameter int InLen  = 16,
    parameter int OutLen = 8
) ();
    localparam int WBits = 2 * InLen * OutLen;

    logic             load_en;
    logic             data_valid;
    logic [7:0]       data_in;
    logic             run;
    logic             err_clr;
    logic [WBits-1:0] W;
    logic             w_valid;
    logic             busy;
    logic             mult_en;
    logic             err;

    modport master (
        output load_en, data_valid, data_in, run, err_clr,
        input  W, w_valid, busy, mult_en, err
    );

    modport slave (
        input  load_en, data_valid, data_in, run, err_clr,
        output W, w_valid, busy, mult_en, err
    );
endinterface

// File: rtl/ternary_weight_loader.sv
// Streams packed 2-bit ternary weights into a shadow buffer and commits the
// whole matrix to W atomically on the last byte; gates the multiplier enable.
module ternary_weight_loader #(
    parameter int InLen  = 16,
    parameter int OutLen = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ternary_weight_loader_if.slave bus
);
    localparam int WBits  = 2 * InLen * OutLen;
    localparam int NBytes = WBits / 8;
    localparam int CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(NBytes - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CntW-1:0]  cnt_reg;
    logic [WBits-1:0] w_reg;
    logic             w_valid_reg;
    logic             mult_en_reg;
    logic             err_reg;

    logic [7:0]       san_byte;
    logic [3:0]       reserved_field;
    logic             accept;
    logic             commit;
    logic             w_valid_next;
    logic             err_next;

    // Reserved code 10 is mapped to zero weight before it can reach W.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sanitise
            assign reserved_field[gi]   = (bus.data_in[2*gi +: 2] == 2'b10);
            assign san_byte[2*gi +: 2]  = reserved_field[gi] ? 2'b00 : bus.data_in[2*gi +: 2];
        end
    endgenerate

    assign accept       = (state_reg == LOAD) && bus.load_en && bus.data_valid;
    assign commit       = accept && (cnt_reg == LastIdx);
    assign w_valid_next = w_valid_reg || commit;

    // A new reserved code outranks a clear request on the same edge.
    always_comb begin
        err_next = err_reg;
        if (accept && (|reserved_field)) begin
            err_next = 1'b1;
        end else if (bus.err_clr) begin
            err_next = 1'b0;
        end
    end

    // Shadow buffer: one register per byte lane except the last, which is
    // taken straight from the input at commit.
    logic [7:0]       shadow_reg [NBytes-1];
    logic [WBits-9:0] shadow_flat;

    generate
        for (gi = 0; gi < NBytes - 1; gi++) begin : g_shadow
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[gi] <= '0;
                end else if (accept && (cnt_reg == CntW'(gi))) begin
                    shadow_reg[gi] <= san_byte;
                end
            end
            assign shadow_flat[8*gi +: 8] = shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            w_reg       <= '0;
            w_valid_reg <= 1'b0;
            mult_en_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            err_reg     <= err_next;
            w_valid_reg <= w_valid_next;
            // Dropping enable for one cycle after commit restarts the
            // multiplier at row 0 with the fresh matrix.
            mult_en_reg <= bus.run && w_valid_next && !commit;

            case (state_reg)
                IDLE: begin
                    if (bus.load_en) begin
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                    end
                end
                LOAD: begin
                    if (!bus.load_en) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (commit) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        w_reg     <= {san_byte, shadow_flat};
                    end else if (accept) begin
                        cnt_reg   <= cnt_reg + CntW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.W       = w_reg;
    assign bus.w_valid = w_valid_reg;
    assign bus.busy    = (state_reg == LOAD);
    assign bus.mult_en = mult_en_reg;
    assign bus.err     = err_reg;
endmodule

// File: tb/tb_ternary_weight_loader.sv
// Directed, table-driven bench for ternary_weight_loader with hand-written
// sequences for abort, gapped load, reload under run and async reset.
module tb_ternary_weight_loader;
    localparam int NB = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ternary_weight_loader_if #(.InLen(16), .OutLen(8)) bus ();

    ternary_weight_loader #(.InLen(16), .OutLen(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_byte;
        logic       exp_err;
    } vec_t;

    vec_t         vecs [10];
    logic [7:0]   bytes_q [NB];
    logic [255:0] exp_w;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] san(input logic [7:0] b);
        logic [7:0] r;
        for (int f = 0; f < 4; f++) begin
            case (b[2*f +: 2])
                2'b10:   r[2*f +: 2] = 2'b00;
                default: r[2*f +: 2] = b[2*f +: 2];
            endcase
        end
        return r;
    endfunction

    // Streams bytes_q; checks that W never shows a partial load and that
    // busy stays high for the whole load and drops at commit.
    task automatic do_load(input bit gap, input string tag);
        logic [255:0] w_before;
        int leaks;
        int busy_cnt;
        w_before = bus.W;
        leaks    = 0;
        busy_cnt = 0;
        bus.load_en    = 1'b1;
        bus.data_valid = 1'b0;
        step;
        if (bus.busy) busy_cnt++;
        for (int k = 0; k < NB; k++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = bytes_q[k];
            step;
            if (bus.busy) busy_cnt++;
            if (k < NB - 1 && (bus.W !== w_before || !bus.busy)) leaks++;
            if (gap && k < NB - 1) begin
                bus.data_valid = 1'b0;
                bus.data_in    = 8'hAA;
                step;
                if (bus.busy) busy_cnt++;
                if (bus.W !== w_before || !bus.busy) leaks++;
            end
        end
        bus.load_en    = 1'b0;
        bus.data_valid = 1'b0;
        chk($sformatf("%s_partial_hidden", tag), 256'(leaks), 256'd0);
        chk($sformatf("%s_busy_cycles", tag), 256'(busy_cnt), gap ? 256'd63 : 256'd32);
        chk($sformatf("%s_busy_after_commit", tag), 256'(bus.busy), 256'd0);
        chk($sformatf("%s_w_valid", tag), 256'(bus.w_valid), 256'd1);
    endtask

    task automatic pulse_err_clr;
        bus.err_clr = 1'b1;
        step;
        bus.err_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 8'h55, 1'b0};
        vecs[1] = '{8'hAA, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0};
        vecs[3] = '{8'h11, 8'h11, 1'b0};
        vecs[4] = '{8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h0A, 8'h00, 1'b1};
        vecs[6] = '{8'hCC, 8'hCC, 1'b0};
        vecs[7] = '{8'hE4, 8'hC4, 1'b1};
        vecs[8] = '{8'h00, 8'h00, 1'b0};
        vecs[9] = '{8'h36, 8'h34, 1'b1};

        rst_n          = 1'b0;
        bus.load_en    = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        bus.run        = 1'b0;
        bus.err_clr    = 1'b0;

        #2;
        chk("rst_W", bus.W, 256'd0);
        chk("rst_w_valid", 256'(bus.w_valid), 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_mult_en", 256'(bus.mult_en), 256'd0);
        chk("rst_err", 256'(bus.err), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step;

        // Abort after 10 bytes of 0xFF: nothing committed.
        bus.load_en = 1'b1;
        step;
        for (int k = 0; k < 10; k++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = 8'hFF;
            step;
        end
        bus.load_en    = 1'b0;
        bus.data_valid = 1'b0;
        step;
        chk("abort_busy", 256'(bus.busy), 256'd0);
        chk("abort_W", bus.W, 256'd0);
        chk("abort_w_valid", 256'(bus.w_valid), 256'd0);
        for (int k = 0; k < NB; k++) bytes_q[k] = 8'h11;
        do_load(1'b0, "reload11");
        chk("reload11_W", bus.W, {32{8'h11}});

        // Table of uniform loads.
        for (int v = 0; v < 10; v++) begin
            pulse_err_clr;
            for (int k = 0; k < NB; k++) bytes_q[k] = vecs[v].din;
            do_load(1'b0, $sformatf("vec%0d", v));
            exp_w = {32{vecs[v].exp_byte}};
            chk($sformatf("vec%0d_W", v), bus.W, exp_w);
            chk($sformatf("vec%0d_err", v), 256'(bus.err), 256'(vecs[v].exp_err));
        end

        // Gapped load of 0x00..0x1F.
        pulse_err_clr;
        chk("gap_err_precleared", 256'(bus.err), 256'd0);
        for (int k = 0; k < NB; k++) begin
            bytes_q[k] = 8'(k);
            exp_w[8*k +: 8] = san(8'(k));
        end
        do_load(1'b1, "gap");
        chk("gap_W", bus.W, exp_w);
        chk("gap_err", 256'(bus.err), 256'd1);
        pulse_err_clr;
        chk("gap_err_cleared", 256'(bus.err), 256'd0);

        // err_clr on the same edge as a reserved byte; abort keeps err.
        bus.load_en = 1'b1;
        step;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h80;
        bus.err_clr    = 1'b1;
        step;
        bus.err_clr    = 1'b0;
        chk("simul_err_wins", 256'(bus.err), 256'd1);
        bus.load_en    = 1'b0;
        bus.data_valid = 1'b0;
        step;
        chk("abort_keeps_err", 256'(bus.err), 256'd1);
        chk("abort_keeps_W", bus.W, exp_w);
        pulse_err_clr;
        chk("err_clr_alone", 256'(bus.err), 256'd0);

        // Reload 0xCC while the multiplier runs.
        bus.run = 1'b1;
        step;
        chk("run_mult_en_on", 256'(bus.mult_en), 256'd1);
        bus.load_en = 1'b1;
        step;
        for (int k = 0; k < NB; k++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = 8'hCC;
            step;
            if (k == NB - 2) chk("run_mult_en_before_commit", 256'(bus.mult_en), 256'd1);
        end
        bus.load_en    = 1'b0;
        bus.data_valid = 1'b0;
        chk("run_W_at_commit", bus.W, {32{8'hCC}});
        chk("run_mult_en_gap", 256'(bus.mult_en), 256'd0);
        step;
        chk("run_mult_en_back", 256'(bus.mult_en), 256'd1);
        bus.run = 1'b0;
        step;
        chk("run_fall_mult_en", 256'(bus.mult_en), 256'd0);

        // Load held high after commit restarts immediately; w_valid stays 1.
        for (int k = 0; k < NB; k++) bytes_q[k] = 8'h44;
        bus.load_en = 1'b1;
        step;
        for (int k = 0; k < NB; k++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = bytes_q[k];
            step;
        end
        bus.data_valid = 1'b0;
        step;
        chk("held_restart_busy", 256'(bus.busy), 256'd1);
        chk("held_w_valid", 256'(bus.w_valid), 256'd1);
        chk("held_W", bus.W, {32{8'h44}});
        bus.load_en = 1'b0;
        step;

        // Async reset in the middle of a load, between clock edges.
        bus.run     = 1'b1;
        bus.err_clr = 1'b0;
        bus.load_en = 1'b1;
        step;
        for (int k = 0; k < 5; k++) begin
            bus.data_valid = 1'b1;
            bus.data_in    = 8'h32;
            step;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_W", bus.W, 256'd0);
        chk("arst_w_valid", 256'(bus.w_valid), 256'd0);
        chk("arst_busy", 256'(bus.busy), 256'd0);
        chk("arst_mult_en", 256'(bus.mult_en), 256'd0);
        chk("arst_err", 256'(bus.err), 256'd0);
        bus.load_en    = 1'b0;
        bus.data_valid = 1'b0;
        bus.run        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step;
        for (int k = 0; k < NB; k++) begin
            bytes_q[k] = 8'(k * 7);
            exp_w[8*k +: 8] = san(8'(k * 7));
        end
        do_load(1'b0, "post_rst");
        chk("post_rst_W", bus.W, exp_w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ternary_weight_loader.md
TERNARY_WEIGHT_LOADER -- requirements
Module: ternary_weight_loader

Interface
REQ-001 SHALL have parameter InLen, default 16, input-vector length of the ternary multiplier.
REQ-002 SHALL have parameter OutLen, default 8, output-vector length of the ternary multiplier.
REQ-003 SHALL derive WBits = 2*InLen*OutLen (default 256) and NBytes = WBits/8 (default 32).
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_en  input  1  level request to load a new weight matrix.
REQ-007 SHALL have port data_valid  input  1  data_in carries a weight byte this cycle.
REQ-008 SHALL have port data_in  input  8  four packed 2-bit ternary weights.
REQ-009 SHALL have port run  input  1  host request to run the multiplier.
REQ-010 SHALL have port err_clr  input  1  clears the sticky error flag.
REQ-011 SHALL have port W  output  WBits  committed weight matrix for the multiplier.
REQ-012 SHALL have port w_valid  output  1  W holds a complete matrix.
REQ-013 SHALL have port busy  output  1  a load is in progress.
REQ-014 SHALL have port mult_en  output  1  registered enable for the multiplier.
REQ-015 SHALL have port err  output  1  sticky flag: a reserved weight code was received.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, LOAD; busy SHALL equal (state == LOAD).
REQ-017 IDLE -> LOAD SHALL occur on the edge where load_en = 1; the byte counter SHALL be set to 0 on that edge.
REQ-018 In IDLE, data_valid SHALL be ignored; no byte is accepted in the cycle load_en first rises.
REQ-019 In LOAD, a byte SHALL be accepted on each edge with load_en = 1 and data_valid = 1; cycles with data_valid = 0 SHALL hold the counter and shadow buffer.
REQ-020 Accepted byte k (0..NBytes-1) SHALL be stored in shadow bits [8k+7:8k]; the counter SHALL increment by 1 per accepted byte.
REQ-021 Each 2-bit field SHALL be sanitised before storage: 00 -> 00, 01 -> 01, 11 -> 11, reserved 10 -> 00.
REQ-022 On the edge accepting byte NBytes-1 (commit), W SHALL load {sanitised byte, shadow[WBits-9:0]} atomically, w_valid SHALL become 1, and state SHALL return to IDLE.
REQ-023 W SHALL change only at commit or reset; partial loads SHALL never be visible on W.
REQ-024 In LOAD, load_en = 0 SHALL abort: state -> IDLE, counter -> 0, W and w_valid unchanged.
REQ-025 load_en held high after commit SHALL start a new load on the next edge (IDLE -> LOAD); w_valid SHALL remain 1 throughout.
REQ-026 Once set, w_valid SHALL stay 1 until reset.
REQ-027 mult_en SHALL be registered: next value = run AND w_valid_next AND NOT commit_this_cycle.
REQ-028 mult_en SHALL therefore be 0 for exactly one cycle after each commit while run = 1, forcing the multiplier to restart at row 0 with the new weights.
REQ-029 mult_en SHALL be 1 one cycle after run rises when w_valid = 1; SHALL be 0 one cycle after run falls.
REQ-030 err SHALL set on the edge accepting any byte containing a 10 field, including the commit byte.
REQ-031 err SHALL clear on an edge with err_clr = 1; a simultaneous new error SHALL win (err stays 1).
REQ-032 An aborted load SHALL NOT clear err.

Reset
REQ-033 On rst_n = 0: state IDLE, counter 0, shadow 0, W = 0, w_valid = 0, busy = 0, mult_en = 0, err = 0.
REQ-034 Reset asserted mid-load SHALL discard the partial load; first post-reset load starts at byte 0.

Verification
REQ-035 Reset: assert rst_n = 0 at arbitrary point -> all outputs 0 immediately, without a clock edge.
REQ-036 Full load: load_en = 1, 32 bytes of 0x55 with data_valid = 1 -> busy high 32 cycles; after 32nd byte edge W = {32{0x55}}, w_valid = 1, busy = 0, err = 0.
REQ-037 Gapped load: 32 bytes 0x00..0x1F with data_valid toggling 1/0 -> W byte k = sanitised k (0x02 -> 0x00, 0x0A -> 0x00, etc.), commit after 64 cycles, err = 1; err_clr = 1 one cycle -> err = 0.
REQ-038 Abort: load 10 bytes of 0xFF then drop load_en -> W unchanged (0), w_valid = 0; reload 32 bytes 0x11 -> W = {32{0x11}}.
REQ-039 Reload while running: w_valid = 1, run = 1, mult_en = 1; complete reload of 0xCC -> W = {32{0xCC}} at commit edge, mult_en = 0 for exactly one cycle then 1.
REQ-040 Simultaneous: err_clr = 1 on same edge as accepting byte 0x80 -> err remains 1.
